// File: rtl/output_uart.sv
// Captures CPU output-register writes into a small FIFO and streams each word
// over an 8N1 UART line, most-significant byte first.
module output_uart #(
  parameter int unsigned DataWidth     = 16,
  parameter int unsigned ClksPerBit    = 4,
  parameter int unsigned FifoDepthLog2 = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Ld,
  input  logic [DataWidth-1:0] DIn,
  output logic                 Tx,
  output logic                 Busy,
  output logic                 Full,
  output logic                 Overflow
);

  localparam int unsigned Depth    = 1 << FifoDepthLog2;
  localparam int unsigned NumBytes = DataWidth / 8;
  localparam int unsigned ByteIdxW = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam int unsigned BaudW    = $clog2(ClksPerBit);
  localparam int unsigned PtrW     = FifoDepthLog2;
  localparam int unsigned CntW     = FifoDepthLog2 + 1;

  localparam logic [BaudW-1:0]    BaudLast = BaudW'(ClksPerBit - 1);
  localparam logic [ByteIdxW-1:0] ByteLast = ByteIdxW'(NumBytes - 1);
  localparam logic [CntW-1:0]     CntFull  = CntW'(Depth);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                state_q;
  logic                  ld_q;
  logic [DataWidth-1:0]  mem [Depth];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  overflow_q;
  logic [BaudW-1:0]      baud_q;
  logic [2:0]            bit_idx_q;
  logic [ByteIdxW-1:0]   byte_idx_q;
  logic [DataWidth-1:0]  shift_q;
  logic                  tx_q;

  logic                  push, pop, push_ok, baud_end;
  logic [7:0]            cur_byte;
  logic [2:0]            bit_nxt;

  // The output register updates on the edge that samples Ld, so push one cycle later.
  assign push     = ld_q;
  assign pop      = (state_q == StIdle) && (count_q != '0);
  assign Full     = (count_q == CntFull);
  assign push_ok  = push && (!Full || pop);
  assign baud_end = (baud_q == BaudLast);
  assign bit_nxt  = bit_idx_q + 3'd1;
  assign cur_byte = 8'(shift_q >> {byte_idx_q, 3'b000});

  assign Tx       = tx_q;
  assign Busy     = (state_q != StIdle) || (count_q != '0);
  assign Overflow = overflow_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ld_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      ld_q <= Ld;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      if (push && !push_ok) overflow_q <= 1'b1;
    end
  end

  // Storage is not reset; the cleared pointers/count keep stale entries unreachable.
  always_ff @(posedge Clk) begin
    if (push_ok) mem[wr_ptr_q] <= DIn;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= StIdle;
      tx_q       <= 1'b1;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (pop) begin
            shift_q    <= mem[rd_ptr_q];
            byte_idx_q <= ByteLast;
            state_q    <= StStart;
            tx_q       <= 1'b0;
          end
        end
        StStart: begin
          if (baud_end) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= StData;
            tx_q      <= cur_byte[0];
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StData: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_nxt;
              tx_q      <= cur_byte[bit_nxt];
            end
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StStop: begin
          if (baud_end) begin
            baud_q <= '0;
            if (byte_idx_q != '0) begin
              byte_idx_q <= byte_idx_q - ByteIdxW'(1);
              state_q    <= StStart;
              tx_q       <= 1'b0;
            end else begin
              state_q <= StIdle;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/output_uart.md
OUTPUT_UART -- requirements
Module: output_uart

Interface
REQ-001 Parameter DataWidth, default 16: width of the captured output word; SHALL be an even multiple of 8.
REQ-002 Parameter ClksPerBit, default 4: Clk cycles per UART bit period; SHALL be >= 2.
REQ-003 Parameter FifoDepthLog2, default 2: FIFO holds 2^FifoDepthLog2 words (4 by default).
REQ-004 Clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 Ld  input  1  output-load strobe from the CPU output-register load control.
REQ-007 DIn  input  DataWidth  CPU output-register contents, valid the cycle after Ld.
REQ-008 Tx  output  1  UART 8N1 serial line; idle high.
REQ-009 Busy  output  1  high while FIFO is non-empty or a frame is in progress.
REQ-010 Full  output  1  high when FIFO count equals 2^FifoDepthLog2.
REQ-011 Overflow  output  1  sticky; set when a word is dropped because the FIFO is full.

Function
REQ-012 Ld SHALL be registered into ld_q; DIn SHALL be pushed on the edge where ld_q=1, because the CPU output register updates on the same edge that samples Ld.
REQ-013 A push with Full=0 SHALL write DIn at the write pointer and increment count; pointers SHALL wrap modulo depth.
REQ-014 A push with Full=1 and no simultaneous pop SHALL be dropped, leave FIFO contents unchanged, and set Overflow.
REQ-015 A push and a pop on the same edge SHALL both take effect, leaving count unchanged; at Full=1 this push SHALL be accepted and SHALL NOT set Overflow.
REQ-016 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-017 IDLE: Tx=1; if FIFO non-empty, pop the head word into the shift holding register, select the upper byte, and go to START.
REQ-018 START: Tx=0 for ClksPerBit cycles, then go to DATA with bit index 0.
REQ-019 DATA: Tx = current byte bit[index], LSB first, each for ClksPerBit cycles; after bit 7, go to STOP.
REQ-020 STOP: Tx=1 for ClksPerBit cycles; if bytes of the held word remain, select the next lower byte and go to START, else go to IDLE.
REQ-021 Bytes of a word SHALL be sent most-significant first; a 16-bit word is 2 back-to-back frames totalling 20*ClksPerBit cycles.
REQ-022 Tx SHALL be driven from a register (glitch-free).
REQ-023 Latency: Ld sampled at edge n -> push at n+1 -> pop at n+2, with Tx falling to 0 after edge n+2 when IDLE and the FIFO is empty.
REQ-024 The baud counter SHALL count 0..ClksPerBit-1 and reset to 0 on every state change.
REQ-025 Busy SHALL be (state != IDLE) OR (count != 0); Full SHALL be combinational from count.
REQ-026 Overflow SHALL remain set until Reset.

Reset
REQ-027 On Reset=1, asynchronously: state=IDLE, Tx=1, Busy=0, Full=0, Overflow=0, count=0, pointers=0, ld_q=0, baud and bit counters=0.
REQ-028 Reset mid-frame SHALL abort the frame and discard FIFO contents; after Reset falls, the block SHALL remain idle until the next Ld.
REQ-029 FIFO storage need not be cleared; unread entries SHALL never be transmitted after reset.

Verification (ClksPerBit=4, DataWidth=16, depth 4)
REQ-030 Single Ld with DIn=16'hA55A -> Tx low 2 edges after the Ld edge; frames 0xA5 then 0x5A, LSB first; Busy falls exactly 80 cycles after Tx first falls.
REQ-031 Ld high for 6 consecutive cycles with words W1..W6 -> W1 popped at once; Full=1 after the 5th push; W6 dropped; Overflow=1; W1..W5 transmitted in order.
REQ-032 FIFO full, FSM returns to IDLE and pops on the same edge as a push -> push accepted, count stays 4, Overflow stays 0.
REQ-033 DIn=16'h00FF -> first frame start, eight 0 bits, stop; second frame start, eight 1 bits, stop; no idle gap between frames.
REQ-034 Reset asserted during the DATA bit 3 of the first frame with 2 words queued -> Tx=1, Busy=0, Full=0, Overflow=0 immediately; Tx stays high for 200 cycles after release.
REQ-035 Four pushes fill the FIFO, then all drain, then four more pushes -> pointer wrap verified; all eight words transmitted in order.
